// File: rtl/hvac_pkg.sv
// Shared types and helpers for the multi-zone HVAC controller.
// Optional feature macro: HVAC_AUTO_MODE_EN (enables the AUTO zone mode).
package hvac_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_GUARD = 3'd1,
        ST_IDLE  = 3'd2,
        ST_HEAT  = 3'd3,
        ST_COOL  = 3'd4
    } zone_state_t;

    // MODE_AUTO is only reachable when HVAC_AUTO_MODE_EN is defined.
    typedef enum logic [1:0] {
        MODE_HEAT = 2'd0,
        MODE_COOL = 2'd1,
        MODE_AUTO = 2'd2
    } zone_mode_t;

    // Counter must hold max(MIN_RUN, GUARD_CYC) - 1; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned min_run,
                                              input int unsigned guard_cyc);
        int unsigned m;
        m = (min_run > guard_cyc) ? min_run : guard_cyc;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Lower hysteresis bound, clamped at zero instead of wrapping.
    function automatic logic [31:0] hyst_lo(input logic [31:0] sp,
                                            input logic [31:0] hyst);
        return (sp >= hyst) ? (sp - hyst) : 32'd0;
    endfunction

    // Upper hysteresis bound, clamped at the largest representable temperature.
    function automatic logic [31:0] hyst_hi(input logic [31:0] sp,
                                            input logic [31:0] hyst,
                                            input logic [31:0] tmax);
        return ((sp + hyst) > tmax) ? tmax : (sp + hyst);
    endfunction

endpackage

// File: rtl/hvac_zone_fsm.sv
// One HVAC zone: Moore state machine, persistent mode register and a shared
// guard / minimum-run counter. Optional macro: HVAC_AUTO_MODE_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_OFF   | zone powered down, off_ind high
// ST_GUARD | compressor lockout, counts GUARD_CYC cycles, lockout high
// ST_IDLE  | powered, waiting for temp to leave the hysteresis band
// ST_HEAT  | heating element driven, at least MIN_RUN cycles
// ST_COOL  | cooling element driven, at least MIN_RUN cycles
module hvac_zone_fsm
    import hvac_pkg::*;
#(
    parameter int TEMP_W    = 8,
    parameter int HYST      = 2,
    parameter int MIN_RUN   = 16,
    parameter int GUARD_CYC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              on,
    input  logic              off,
    input  logic              heat_sel,
    input  logic              cool_sel,
    input  logic [TEMP_W-1:0] temp,
    input  logic [TEMP_W-1:0] setpoint,
    output logic              display,
    output logic              heat_en,
    output logic              cool_en,
    output logic              off_ind,
    output logic              lockout
);

    localparam int CNT_W = int'(cnt_width(MIN_RUN, GUARD_CYC));
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(MIN_RUN - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam int BND_W = TEMP_W + 1;
    localparam int unsigned TEMP_MAX = (2 ** TEMP_W) - 1;

    zone_state_t      state_q, state_d;
    zone_mode_t       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [TEMP_W:0]  temp_x, sp_x, lo_b, hi_b;
    logic             below, above, heat_ok, cool_ok;

    // Hysteresis bounds at TEMP_W+1 bits so neither edge of the band can wrap.
    always_comb begin
        temp_x  = {1'b0, temp};
        sp_x    = {1'b0, setpoint};
        lo_b    = BND_W'(hyst_lo(32'(sp_x), 32'(HYST)));
        hi_b    = BND_W'(hyst_hi(32'(sp_x), 32'(HYST), 32'(TEMP_MAX)));
        below   = (temp_x < lo_b);
        above   = (temp_x > hi_b);
        heat_ok = (mode_q == MODE_HEAT) || (mode_q == MODE_AUTO);
        cool_ok = (mode_q == MODE_COOL) || (mode_q == MODE_AUTO);
    end

    // State, mode and counter registers; reset leaves the zone OFF in HEAT mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_OFF;
            mode_q  <= MODE_HEAT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: off beats on, mode select is an independent register.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;

        if (heat_sel && cool_sel) begin
`ifdef HVAC_AUTO_MODE_EN
            mode_d = MODE_AUTO;
`else
            mode_d = MODE_HEAT;
`endif
        end else if (heat_sel) begin
            mode_d = MODE_HEAT;
        end else if (cool_sel) begin
            mode_d = MODE_COOL;
        end

        if (off) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else if (on && (state_q == ST_OFF)) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    cnt_d = '0;
                end
                ST_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (heat_ok && below) begin
                        state_d = ST_HEAT;
                        cnt_d   = '0;
                    end else if (cool_ok && above) begin
                        state_d = ST_COOL;
                        cnt_d   = '0;
                    end
                end
                ST_HEAT: begin
                    if (cnt_q != RUN_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if ((temp_x >= sp_x) || !heat_ok) begin
                        state_d = ST_GUARD;
                        cnt_d   = '0;
                    end
                end
                ST_COOL: begin
                    if (cnt_q != RUN_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if ((temp_x <= sp_x) || !cool_ok) begin
                        state_d = ST_GUARD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Moore outputs decoded purely from the state register.
    always_comb begin
        display = (state_q != ST_OFF);
        off_ind = (state_q == ST_OFF);
        heat_en = (state_q == ST_HEAT);
        cool_en = (state_q == ST_COOL);
        lockout = (state_q == ST_GUARD);
    end

endmodule

// File: rtl/hvac_zone_ctrl.sv
// Multi-zone HVAC controller: ZONES independent copies of hvac_zone_fsm,
// each driven by its own slice of the command and temperature buses.
// Optional macro: HVAC_AUTO_MODE_EN (heat_sel+cool_sel selects AUTO mode).
module hvac_zone_ctrl
    import hvac_pkg::*;
#(
    parameter int ZONES     = 2,
    parameter int TEMP_W    = 8,
    parameter int HYST      = 2,
    parameter int MIN_RUN   = 16,
    parameter int GUARD_CYC = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ZONES-1:0]         on,
    input  logic [ZONES-1:0]         off,
    input  logic [ZONES-1:0]         heat_sel,
    input  logic [ZONES-1:0]         cool_sel,
    input  logic [ZONES*TEMP_W-1:0]  temp,
    input  logic [ZONES*TEMP_W-1:0]  setpoint,
    output logic [ZONES-1:0]         display,
    output logic [ZONES-1:0]         heat_en,
    output logic [ZONES-1:0]         cool_en,
    output logic [ZONES-1:0]         off_ind,
    output logic [ZONES-1:0]         lockout
);

    // One independent controller per zone; no shared arbitration.
    for (genvar z = 0; z < ZONES; z++) begin : g_zone
        hvac_zone_fsm #(
            .TEMP_W   (TEMP_W),
            .HYST     (HYST),
            .MIN_RUN  (MIN_RUN),
            .GUARD_CYC(GUARD_CYC)
        ) u_zone (
            .clk     (clk),
            .reset   (reset),
            .on      (on[z]),
            .off     (off[z]),
            .heat_sel(heat_sel[z]),
            .cool_sel(cool_sel[z]),
            .temp    (temp[z*TEMP_W +: TEMP_W]),
            .setpoint(setpoint[z*TEMP_W +: TEMP_W]),
            .display (display[z]),
            .heat_en (heat_en[z]),
            .cool_en (cool_en[z]),
            .off_ind (off_ind[z]),
            .lockout (lockout[z])
        );
    end

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// Bench for hvac_zone_ctrl: directed scenarios plus random commands, all
// checked against a cycle-level behavioural model of the zone rules.
module tb_hvac_zone_ctrl;

    localparam int ZONES     = 4;
    localparam int TEMP_W    = 8;
    localparam int HYST      = 2;
    localparam int MIN_RUN   = 16;
    localparam int GUARD_CYC = 8;
    localparam int TMAX      = 255;

    localparam int S_OFF = 0, S_GUARD = 1, S_IDLE = 2, S_HEAT = 3, S_COOL = 4;
    localparam int M_HEAT = 0, M_COOL = 1, M_AUTO = 2;
`ifdef HVAC_AUTO_MODE_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic [ZONES-1:0]        on, off, heat_sel, cool_sel;
    logic [ZONES*TEMP_W-1:0] temp, setpoint;
    logic [ZONES-1:0]        display, heat_en, cool_en, off_ind, lockout;

    int errors = 0;
    int checks = 0;

    int m_st[ZONES];
    int m_mode[ZONES];
    int m_age[ZONES];

    always #5 clk = ~clk;

    hvac_zone_ctrl #(
        .ZONES(ZONES), .TEMP_W(TEMP_W), .HYST(HYST),
        .MIN_RUN(MIN_RUN), .GUARD_CYC(GUARD_CYC)
    ) dut (
        .clk(clk), .reset(reset), .on(on), .off(off),
        .heat_sel(heat_sel), .cool_sel(cool_sel),
        .temp(temp), .setpoint(setpoint),
        .display(display), .heat_en(heat_en), .cool_en(cool_en),
        .off_ind(off_ind), .lockout(lockout)
    );

    function automatic int get_t(int z);
        return int'(temp[z*TEMP_W +: TEMP_W]);
    endfunction

    function automatic int get_sp(int z);
        return int'(setpoint[z*TEMP_W +: TEMP_W]);
    endfunction

    task automatic set_t(int z, int v);
        temp[z*TEMP_W +: TEMP_W] = TEMP_W'(v);
    endtask

    task automatic set_sp(int z, int v);
        setpoint[z*TEMP_W +: TEMP_W] = TEMP_W'(v);
    endtask

    task automatic model_reset();
        for (int z = 0; z < ZONES; z++) begin
            m_st[z]   = S_OFF;
            m_mode[z] = M_HEAT;
            m_age[z]  = 0;
        end
    endtask

    // One clock of the zone rules; age = cycles already spent in the state.
    task automatic model_step();
        if (!reset) begin
            model_reset();
            return;
        end
        for (int z = 0; z < ZONES; z++) begin
            int t, sp, lo, hi, nst;
            bit can_h, can_c;
            t     = get_t(z);
            sp    = get_sp(z);
            lo    = (sp > HYST) ? sp - HYST : 0;
            hi    = (sp + HYST > TMAX) ? TMAX : sp + HYST;
            can_h = (m_mode[z] == M_HEAT) || (m_mode[z] == M_AUTO);
            can_c = (m_mode[z] == M_COOL) || (m_mode[z] == M_AUTO);
            nst   = m_st[z];
            if (off[z])
                nst = S_OFF;
            else if (on[z] && m_st[z] == S_OFF)
                nst = S_GUARD;
            else if (m_st[z] == S_GUARD && m_age[z] + 1 >= GUARD_CYC)
                nst = S_IDLE;
            else if (m_st[z] == S_IDLE && can_h && t < lo)
                nst = S_HEAT;
            else if (m_st[z] == S_IDLE && can_c && t > hi)
                nst = S_COOL;
            else if (m_st[z] == S_HEAT && m_age[z] + 1 >= MIN_RUN && (t >= sp || !can_h))
                nst = S_GUARD;
            else if (m_st[z] == S_COOL && m_age[z] + 1 >= MIN_RUN && (t <= sp || !can_c))
                nst = S_GUARD;
            m_age[z] = (nst != m_st[z]) ? 0 : m_age[z] + 1;
            m_st[z]  = nst;
            if (heat_sel[z] && cool_sel[z])
                m_mode[z] = AUTO_EN ? M_AUTO : M_HEAT;
            else if (heat_sel[z])
                m_mode[z] = M_HEAT;
            else if (cool_sel[z])
                m_mode[z] = M_COOL;
        end
    endtask

    function automatic logic [5*ZONES-1:0] obs_vec();
        return {display, heat_en, cool_en, off_ind, lockout};
    endfunction

    function automatic logic [5*ZONES-1:0] exp_vec();
        logic [ZONES-1:0] d, h, c, o, l;
        for (int z = 0; z < ZONES; z++) begin
            d[z] = (m_st[z] != S_OFF);
            h[z] = (m_st[z] == S_HEAT);
            c[z] = (m_st[z] == S_COOL);
            o[z] = (m_st[z] == S_OFF);
            l[z] = (m_st[z] == S_GUARD);
        end
        return {d, h, c, o, l};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic all_off();
        on = '0; heat_sel = '0; cool_sel = '0; off = '1;
        tick();
        off = '0;
    endtask

    task automatic test_reset();
        logic [5*ZONES-1:0] want;
        want = {{ZONES{1'b0}}, {ZONES{1'b0}}, {ZONES{1'b0}}, {ZONES{1'b1}}, {ZONES{1'b0}}};
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            on = ZONES'($urandom); off = ZONES'($urandom);
            heat_sel = ZONES'($urandom); cool_sel = ZONES'($urandom);
            temp = (ZONES*TEMP_W)'($urandom); setpoint = (ZONES*TEMP_W)'($urandom);
            @(posedge clk); #1;
            if (obs_vec() !== want) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h want %h", i, obs_vec(), want);
            end
            checks++;
        end
        on = '0; off = '0; heat_sel = '0; cool_sel = '0;
        for (int z = 0; z < ZONES; z++) begin set_t(z, 20); set_sp(z, 20); end
        reset = 1'b1;
        tick();
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_power_on();
        int lock_cnt, heat_cnt;
        set_t(0, 15); set_sp(0, 20);
        on[0] = 1'b1;
        tick();
        on[0] = 1'b0;
        lock_cnt = 0;
        for (int i = 0; i < 40 && lockout[0]; i++) begin
            lock_cnt++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL power_guard cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
            tick();
        end
        if (lock_cnt !== GUARD_CYC) begin
            errors++;
            $display("FAIL lockout_len: got %0d want %0d", lock_cnt, GUARD_CYC);
        end
        checks++;
        if ({display[0], heat_en[0], lockout[0]} !== 3'b100) begin
            errors++;
            $display("FAIL idle_after_guard: got %b want 100", {display[0], heat_en[0], lockout[0]});
        end
        checks++;
        tick();
        if (heat_en[0] !== 1'b1) begin
            errors++;
            $display("FAIL heat_start: got %b want 1", heat_en[0]);
        end
        checks++;
        heat_cnt = 0;
        for (int i = 0; i < 60 && heat_en[0]; i++) begin
            heat_cnt++;
            if (heat_cnt == 3) set_t(0, 20);
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL power_heat cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
            tick();
        end
        if (heat_cnt !== MIN_RUN) begin
            errors++;
            $display("FAIL min_run_len: got %0d want %0d", heat_cnt, MIN_RUN);
        end
        checks++;
        if (lockout[0] !== 1'b1) begin
            errors++;
            $display("FAIL guard_after_heat: got %b want 1", lockout[0]);
        end
        checks++;
        all_off();
    endtask

    task automatic test_off_during_heat();
        heat_sel[0] = 1'b1; tick(); heat_sel[0] = 1'b0;
        set_t(0, 15); set_sp(0, 20);
        on[0] = 1'b1; tick(); on[0] = 1'b0;
        repeat (GUARD_CYC + 1) tick();
        if (heat_en[0] !== 1'b1) begin
            errors++;
            $display("FAIL off_heat_start: got %b want 1", heat_en[0]);
        end
        checks++;
        repeat (3) tick();
        off[0] = 1'b1; tick(); off[0] = 1'b0;
        if ({heat_en[0], off_ind[0]} !== 2'b01) begin
            errors++;
            $display("FAIL off_in_heat: got %b want 01", {heat_en[0], off_ind[0]});
        end
        checks++;
        on[0] = 1'b1; off[0] = 1'b1; tick(); on[0] = 1'b0; off[0] = 1'b0;
        if ({off_ind[0], lockout[0]} !== 2'b10 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL on_off_same: got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_cool_hyst();
        all_off();
        cool_sel[0] = 1'b1; tick(); cool_sel[0] = 1'b0;
        set_sp(0, 20); set_t(0, 22);
        on[0] = 1'b1; tick(); on[0] = 1'b0;
        repeat (GUARD_CYC + 4) tick();
        if ({display[0], cool_en[0], lockout[0]} !== 3'b100) begin
            errors++;
            $display("FAIL cool_band_edge: got %b want 100", {display[0], cool_en[0], lockout[0]});
        end
        checks++;
        set_t(0, 23); tick();
        if (cool_en[0] !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL cool_start: got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
        all_off();
        set_sp(0, 254); set_t(0, 255);
        on[0] = 1'b1; tick(); on[0] = 1'b0;
        repeat (GUARD_CYC + 4) tick();
        if ({display[0], cool_en[0]} !== 2'b10) begin
            errors++;
            $display("FAIL cool_upper_clamp: got %b want 10", {display[0], cool_en[0]});
        end
        checks++;
        all_off();
        heat_sel[0] = 1'b1; tick(); heat_sel[0] = 1'b0;
        set_sp(0, 1); set_t(0, 0);
        on[0] = 1'b1; tick(); on[0] = 1'b0;
        repeat (GUARD_CYC + 4) tick();
        if ({display[0], heat_en[0]} !== 2'b10) begin
            errors++;
            $display("FAIL heat_lower_clamp: got %b want 10", {display[0], heat_en[0]});
        end
        checks++;
        all_off();
    endtask

    task automatic test_auto();
        int lock_cnt, first_cool;
        heat_sel[0] = 1'b1; cool_sel[0] = 1'b1; tick();
        heat_sel[0] = 1'b0; cool_sel[0] = 1'b0;
        set_sp(0, 20); set_t(0, 10);
        on[0] = 1'b1; tick(); on[0] = 1'b0;
        repeat (GUARD_CYC + 1) tick();
        if (heat_en[0] !== 1'b1) begin
            errors++;
            $display("FAIL auto_heat: got %b want 1", heat_en[0]);
        end
        checks++;
        set_t(0, 30);
        lock_cnt = 0;
        first_cool = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (lockout[0] && first_cool < 0) lock_cnt++;
            if (cool_en[0] && first_cool < 0) first_cool = i;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL auto_swing cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
        if (AUTO_EN) begin
            if (first_cool < 0 || lock_cnt != GUARD_CYC) begin
                errors++;
                $display("FAIL auto_cool_via_guard: got cool_at=%0d guard=%0d want guard=%0d",
                         first_cool, lock_cnt, GUARD_CYC);
            end
        end else begin
            if (first_cool >= 0 || heat_en[0] !== 1'b0) begin
                errors++;
                $display("FAIL heat_only: got cool_at=%0d heat=%b want no cool, heat 0",
                         first_cool, heat_en[0]);
            end
        end
        checks++;
        all_off();
    endtask

    task automatic test_multi_zone();
        all_off();
        heat_sel = 4'b0010; cool_sel = 4'b0100; tick();
        heat_sel = '0; cool_sel = '0;
        set_sp(1, 20); set_t(1, 10);
        set_sp(2, 20); set_t(2, 30);
        set_sp(0, 20); set_t(0, 5);
        on = 4'b0110; tick(); on = '0;
        for (int i = 0; i < 40; i++) begin
            heat_sel[3] = ($urandom_range(0, 3) == 0);
            cool_sel[3] = ($urandom_range(0, 3) == 0);
            set_t(3, int'($urandom_range(0, 255)));
            set_sp(3, int'($urandom_range(0, 255)));
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL multi_zone cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (i == GUARD_CYC) begin
                if ({heat_en, cool_en, off_ind} !== {4'b0010, 4'b0100, 4'b1001}) begin
                    errors++;
                    $display("FAIL multi_concurrent: got %b want 001001001001",
                             {heat_en, cool_en, off_ind});
                end
                checks++;
            end
        end
        heat_sel = '0; cool_sel = '0;
        all_off();
    endtask

    task automatic test_reset_midrun();
        heat_sel[0] = 1'b1; tick(); heat_sel[0] = 1'b0;
        set_sp(0, 20); set_t(0, 15);
        on[0] = 1'b1; tick(); on[0] = 1'b0;
        repeat (GUARD_CYC + 3) tick();
        if (heat_en[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrun_heat: got %b want 1", heat_en[0]);
        end
        checks++;
        #2 reset = 1'b0;
        #1;
        if ({heat_en, cool_en, display, off_ind} !== {12'h000, 4'hF}) begin
            errors++;
            $display("FAIL async_reset: got %h want 000f", {heat_en, cool_en, display, off_ind});
        end
        checks++;
        model_reset();
        #1 reset = 1'b1;
        tick();
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL after_reset: got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            for (int z = 0; z < ZONES; z++) begin
                int sel, v;
                off[z] = ($urandom_range(0, 59) == 0);
                on[z]  = ($urandom_range(0, 9) == 0);
                if (off[z]) begin
                    heat_sel[z] = 1'b0;
                    cool_sel[z] = 1'b0;
                end else begin
                    heat_sel[z] = ($urandom_range(0, 24) == 0);
                    cool_sel[z] = ($urandom_range(0, 24) == 0);
                end
                if ($urandom_range(0, 15) == 0) begin
                    sel = int'($urandom_range(0, 3));
                    if (sel == 0)      set_sp(z, int'($urandom_range(0, 3)));
                    else if (sel == 1) set_sp(z, int'($urandom_range(252, 255)));
                    else               set_sp(z, int'($urandom_range(10, 240)));
                end
                if ($urandom_range(0, 3) == 0) begin
                    v = get_sp(z) + int'($urandom_range(0, 12)) - 6;
                    if (v < 0) v = 0;
                    if (v > TMAX) v = TMAX;
                    set_t(z, v);
                end
            end
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
        all_off();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        on = '0; off = '0; heat_sel = '0; cool_sel = '0;
        temp = '0; setpoint = '0;
        model_reset();
        test_reset();
        test_power_on();
        test_off_during_heat();
        test_cool_hyst();
        test_auto();
        test_multi_zone();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hvac_zone_ctrl.md
# hvac_zone_ctrl

- Parametrised multi-zone successor to the single-zone on/heat/cool/off HVAC controller.
- Each of `ZONES` zones runs its own Moore state machine with a persistent mode register, and hysteresis thermostat control against a per-zone setpoint.
- Adds compressor protection on every zone: minimum run time and a guard (lockout) interval.
- Sits between the user command decoder and the per-zone heating/cooling element drivers.

## Interface

Parameters:
- `ZONES`, 2, number of independent zones (1–8)
- `TEMP_W`, 8, unsigned temperature/setpoint width
- `HYST`, 2, hysteresis band in temperature LSBs (< 2^(TEMP_W-1))
- `MIN_RUN`, 16, minimum cycles heat/cool stays asserted (≥1)
- `GUARD_CYC`, 8, lockout cycles after any element turn-off or power-on (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `on` in ZONES: per-zone turn-on command
- `off` in ZONES: per-zone turn-off command
- `heat_sel` in ZONES: select heating mode
- `cool_sel` in ZONES: select cooling mode
- `temp` in ZONES*TEMP_W: measured temperature; zone z occupies bits [z*TEMP_W +: TEMP_W]
- `setpoint` in ZONES*TEMP_W: target temperature, same packing as `temp`
- `display` out ZONES: 1 when zone is not OFF
- `heat_en` out ZONES: heating element drive
- `cool_en` out ZONES: cooling element drive
- `off_ind` out ZONES: 1 when zone is OFF
- `lockout` out ZONES: 1 while zone is in GUARD

## Operation

- Per-zone states: OFF, GUARD, IDLE, HEAT, COOL. Per-zone mode register: HEAT or COOL (AUTO when enabled).
- Command priority each cycle: `off` > `on` > mode select. Commands are level-sampled at every posedge.
- `off`: any state goes to OFF next cycle. This bypasses `MIN_RUN` and the guard interval.
- `on` in OFF: goes to GUARD. `on` in any other state is ignored.
- Mode select is accepted in every state, including OFF:
  - `heat_sel` alone sets mode HEAT; `cool_sel` alone sets mode COOL.
  - `heat_sel` and `cool_sel` together: see Configuration.
- GUARD: counter loaded to 0 on entry; exits to IDLE when counter reaches GUARD_CYC-1.
- IDLE → HEAT when mode permits heating and temp < setpoint − HYST.
- IDLE → COOL when mode permits cooling and temp > setpoint + HYST.
- HEAT/COOL: counter loaded to 0 on entry and saturates at MIN_RUN-1. Exit is evaluated only once saturated. Exit → GUARD when either:
  - HEAT: temp ≥ setpoint, or mode no longer permits heating;
  - COOL: temp ≤ setpoint, or mode no longer permits cooling.
- Arithmetic: setpoint ± HYST is computed at TEMP_W+1 bits, unsigned. The lower bound clamps at 0 and the upper bound clamps at 2^TEMP_W−1, so there is no wrap.
- Outputs are decoded from the state register only:
  - `display` = state≠OFF; `off_ind` = state==OFF;
  - `heat_en` = HEAT; `cool_en` = COOL; `lockout` = GUARD.
- Zones are fully independent; there is no shared arbitration.

## Timing

- Reset (`reset`=0, asynchronous) puts every zone in state OFF with mode HEAT and counter 0.
- Output values during reset: `display`=0, `heat_en`=0, `cool_en`=0, `lockout`=0, `off_ind`=1.
- Reset mid-run drops `heat_en`/`cool_en` immediately, without waiting for a clock edge.
- Command-to-output latency is 1 cycle: the output changes after the posedge that samples the command.
- `heat_en`/`cool_en` stay high for at least MIN_RUN cycles unless `off` or reset intervenes.
- `lockout` stays high for exactly GUARD_CYC cycles.
- Minimum power-on-to-element latency is GUARD_CYC+2 cycles after `on`.
- Counter width is $clog2(max(MIN_RUN,GUARD_CYC)).

## Configuration

- `HVAC_AUTO_MODE_EN` defined:
  - `heat_sel`&&`cool_sel` together select AUTO.
  - In AUTO, IDLE may enter either HEAT or COOL according to the temperature rules.
  - Switching from HEAT to COOL always passes through GUARD.
- `HVAC_AUTO_MODE_EN` undefined:
  - `heat_sel`&&`cool_sel` together select HEAT.
  - The AUTO encoding is unused and unreachable.

## Structure

- Package `hvac_pkg` holds:
  - `zone_state_t` (OFF, GUARD, IDLE, HEAT, COOL);
  - `zone_mode_t` (HEAT, COOL, AUTO);
  - the hysteresis bound helper function.
- Sub-module `hvac_zone_fsm`: one zone's state, mode and counter. It is instantiated ZONES times by a generate loop in `hvac_zone_ctrl`.

## Test plan

- Reset with `reset`=0 and random inputs → all zones OFF, `off_ind`=all ones, every other output 0.
- Zone 0, defaults: pulse `on`, hold temp=15, setpoint=20 → `lockout` high 8 cycles, then IDLE, then `heat_en`=1 the following cycle. Raise temp to 20 after 3 cycles → `heat_en` still high for 16 cycles total, then GUARD.
- `off` asserted during HEAT at cycle 4 → `heat_en`=0 and `off_ind`=1 the next cycle. Simultaneous `on`+`off` → zone stays OFF.
- Cool mode, setpoint=20, temp=22 → stays IDLE because 22 is not above 22. temp=23 → `cool_en`. Setpoint=254, HYST=2 → upper bound clamps to 255 with no wrap.
- With `HVAC_AUTO_MODE_EN`: `heat_sel`+`cool_sel`, temp swings 10→30 → HEAT, then GUARD 8 cycles, then COOL. Without the macro → heat only, and `cool_en` is never 1.
- ZONES=4, zone 1 heating and zone 2 cooling concurrently, zone 3 OFF → no cross-zone interference on any output.
